// File: rtl/rob_pkg.sv
// Shared types and default sizing for the ROB recovery logic.
package rob_pkg;

    localparam int unsigned ROB_DEPTH      = 64;
    localparam int unsigned ROB_WALK_WIDTH = 2;
    localparam int unsigned ROB_ARCH_REGS  = 64;
    localparam int unsigned ROB_PHYS_REGS  = 128;

    localparam int unsigned IDX_W = $clog2(ROB_DEPTH);
    localparam int unsigned AR_W  = $clog2(ROB_ARCH_REGS);
    localparam int unsigned PR_W  = $clog2(ROB_PHYS_REGS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } rec_state_e;

    // One ROB entry as seen by the recovery walk.
    typedef struct packed {
        logic            wen;
        logic [AR_W-1:0] arch;
        logic [PR_W-1:0] t;
        logic [PR_W-1:0] told;
    } walk_lane_t;

endpackage

// File: rtl/rob_age_cmp.sv
// ROB age comparator: a is older than b when it sits closer to the head.
module rob_age_cmp
    import rob_pkg::*;
#(
    parameter int unsigned IDX_BITS = IDX_W
) (
    input  logic [IDX_BITS-1:0] head,
    input  logic [IDX_BITS-1:0] a,
    input  logic [IDX_BITS-1:0] b,
    output logic                a_older_than_b
);

    logic [IDX_BITS-1:0] age_a;
    logic [IDX_BITS-1:0] age_b;

    // Age is the modular distance from the head.
    always_comb begin
        age_a          = a - head;
        age_b          = b - head;
        a_older_than_b = (age_a < age_b);
    end

endmodule

// File: rtl/rob_recovery_ctrl.sv
// Branch-mispredict recovery sequencer: walks squashed ROB entries
// youngest-first, restores map-table entries, returns freed PRFs and
// finally rewinds the ROB tail.
// Optional macro ROB_RECOVERY_PERF_EN adds saturating perf counters.
module rob_recovery_ctrl
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH      = ROB_DEPTH,
    parameter int unsigned WALK_WIDTH = ROB_WALK_WIDTH,
    parameter int unsigned ARCH_REGS  = ROB_ARCH_REGS,
    parameter int unsigned PHYS_REGS  = ROB_PHYS_REGS,
    localparam int unsigned IDX_BITS  = $clog2(DEPTH),
    localparam int unsigned AR_BITS   = $clog2(ARCH_REGS),
    localparam int unsigned PR_BITS   = $clog2(PHYS_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_req_i,
    input  logic [IDX_BITS-1:0]            flush_rob_idx_i,
    input  logic [IDX_BITS-1:0]            rob_head_i,
    input  logic [IDX_BITS-1:0]            rob_tail_i,
    output logic [IDX_BITS*WALK_WIDTH-1:0] walk_rd_idx_o,
    output logic [WALK_WIDTH-1:0]          walk_rd_en_o,
    input  logic [WALK_WIDTH-1:0]          walk_rd_wen_i,
    input  logic [AR_BITS*WALK_WIDTH-1:0]  walk_rd_arch_i,
    input  logic [PR_BITS*WALK_WIDTH-1:0]  walk_new_prf_i,
    input  logic [PR_BITS*WALK_WIDTH-1:0]  walk_old_prf_i,
    output logic [WALK_WIDTH-1:0]          restore_valid_o,
    output logic [AR_BITS*WALK_WIDTH-1:0]  restore_arch_o,
    output logic [PR_BITS*WALK_WIDTH-1:0]  restore_prf_o,
    output logic [WALK_WIDTH-1:0]          free_valid_o,
    output logic [PR_BITS*WALK_WIDTH-1:0]  free_prf_o,
    output logic                           tail_set_o,
    output logic [IDX_BITS-1:0]            tail_set_idx_o,
    output logic                           disp_stall_o,
    output logic                           busy_o
`ifdef ROB_RECOVERY_PERF_EN
    ,
    output logic [31:0]                    perf_flush_cnt_o,
    output logic [31:0]                    perf_walk_cyc_o
`endif
);

    localparam logic [IDX_BITS-1:0] WW_IDX = IDX_BITS'(WALK_WIDTH);

    rec_state_e          state_q, state_d;
    logic [IDX_BITS-1:0] ptr_q, ptr_d;
    logic [IDX_BITS-1:0] target_q, target_d;
    logic [IDX_BITS-1:0] rem_q, rem_d;
    logic [IDX_BITS-1:0] step, ptr_after, rem_after, rem_init;
    logic                new_older;
    logic                retarget;

    rob_age_cmp #(
        .IDX_BITS(IDX_BITS)
    ) u_age_cmp (
        .head           (rob_head_i),
        .a              (flush_rob_idx_i),
        .b              (target_q),
        .a_older_than_b (new_older)
    );

    // Walk arithmetic shared by next-state and retarget logic.
    always_comb begin
        step      = (rem_q < WW_IDX) ? rem_q : WW_IDX;
        ptr_after = ptr_q - step;
        rem_after = rem_q - step;
        rem_init  = rob_tail_i - IDX_BITS'(1) - flush_rob_idx_i;
        retarget  = flush_req_i && (state_q != IDLE) && new_older;
    end

    // State and walk registers; async reset aborts any walk in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            target_q <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            target_q <= target_d;
            rem_q    <= rem_d;
        end
    end

    // Next-state: a retarget counts from the entry after this cycle's lanes
    // so nothing already undone is revisited.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        target_d = target_q;
        rem_d    = rem_q;
        case (state_q)
            IDLE: begin
                if (flush_req_i) begin
                    target_d = flush_rob_idx_i;
                    ptr_d    = rob_tail_i - IDX_BITS'(1);
                    rem_d    = rem_init;
                    state_d  = (rem_init == '0) ? DONE : WALK;
                end
            end
            WALK: begin
                ptr_d   = ptr_after;
                rem_d   = rem_after;
                state_d = (rem_after == '0) ? DONE : WALK;
                if (retarget) begin
                    target_d = flush_rob_idx_i;
                    rem_d    = ptr_after - flush_rob_idx_i;
                    state_d  = WALK;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (retarget) begin
                    target_d = flush_rob_idx_i;
                    rem_d    = ptr_q - flush_rob_idx_i;
                    state_d  = WALK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-lane read, restore and free strobes; data is zeroed when not valid.
    always_comb begin
        walk_rd_idx_o   = '0;
        walk_rd_en_o    = '0;
        restore_valid_o = '0;
        restore_arch_o  = '0;
        restore_prf_o   = '0;
        free_valid_o    = '0;
        free_prf_o      = '0;
        for (int unsigned k = 0; k < WALK_WIDTH; k++) begin
            if ((state_q == WALK) && (rem_q > IDX_BITS'(k))) begin
                walk_rd_en_o[k]                       = 1'b1;
                walk_rd_idx_o[k*IDX_BITS +: IDX_BITS] = ptr_q - IDX_BITS'(k);
                if (walk_rd_wen_i[k]) begin
                    restore_valid_o[k]                  = 1'b1;
                    free_valid_o[k]                     = 1'b1;
                    restore_arch_o[k*AR_BITS +: AR_BITS] = walk_rd_arch_i[k*AR_BITS +: AR_BITS];
                    restore_prf_o[k*PR_BITS +: PR_BITS]  = walk_old_prf_i[k*PR_BITS +: PR_BITS];
                    free_prf_o[k*PR_BITS +: PR_BITS]     = walk_new_prf_i[k*PR_BITS +: PR_BITS];
                end
            end
        end
    end

    // Tail rewind fires only on the final DONE, never on one that retargets.
    always_comb begin
        tail_set_o     = (state_q == DONE) && !retarget;
        tail_set_idx_o = tail_set_o ? (target_q + IDX_BITS'(1)) : '0;
        busy_o         = (state_q != IDLE);
        disp_stall_o   = (state_q != IDLE);
    end

`ifdef ROB_RECOVERY_PERF_EN
    // Saturating counters: accepted idle flushes and non-idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_flush_cnt_o <= '0;
            perf_walk_cyc_o  <= '0;
        end else begin
            if ((state_q == IDLE) && flush_req_i && (perf_flush_cnt_o != '1))
                perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
            if ((state_q != IDLE) && (perf_walk_cyc_o != '1))
                perf_walk_cyc_o <= perf_walk_cyc_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Self-checking bench for rob_recovery_ctrl (DEPTH=8, WALK_WIDTH=2).
// Reference model: a queue of entries still to be undone, youngest first.
module tb_rob_recovery_ctrl;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_req_i;
    logic [2:0]  flush_rob_idx_i;
    logic [2:0]  rob_head_i;
    logic [2:0]  rob_tail_i;
    logic [5:0]  walk_rd_idx_o;
    logic [1:0]  walk_rd_en_o;
    logic [1:0]  walk_rd_wen_i;
    logic [11:0] walk_rd_arch_i;
    logic [13:0] walk_new_prf_i;
    logic [13:0] walk_old_prf_i;
    logic [1:0]  restore_valid_o;
    logic [11:0] restore_arch_o;
    logic [13:0] restore_prf_o;
    logic [1:0]  free_valid_o;
    logic [13:0] free_prf_o;
    logic        tail_set_o;
    logic [2:0]  tail_set_idx_o;
    logic        disp_stall_o;
    logic        busy_o;
`ifdef ROB_RECOVERY_PERF_EN
    logic [31:0] perf_flush_cnt_o;
    logic [31:0] perf_walk_cyc_o;
`endif

    rob_recovery_ctrl #(
        .DEPTH      (8),
        .WALK_WIDTH (2),
        .ARCH_REGS  (64),
        .PHYS_REGS  (128)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_req_i     (flush_req_i),
        .flush_rob_idx_i (flush_rob_idx_i),
        .rob_head_i      (rob_head_i),
        .rob_tail_i      (rob_tail_i),
        .walk_rd_idx_o   (walk_rd_idx_o),
        .walk_rd_en_o    (walk_rd_en_o),
        .walk_rd_wen_i   (walk_rd_wen_i),
        .walk_rd_arch_i  (walk_rd_arch_i),
        .walk_new_prf_i  (walk_new_prf_i),
        .walk_old_prf_i  (walk_old_prf_i),
        .restore_valid_o (restore_valid_o),
        .restore_arch_o  (restore_arch_o),
        .restore_prf_o   (restore_prf_o),
        .free_valid_o    (free_valid_o),
        .free_prf_o      (free_prf_o),
        .tail_set_o      (tail_set_o),
        .tail_set_idx_o  (tail_set_idx_o),
        .disp_stall_o    (disp_stall_o),
        .busy_o          (busy_o)
`ifdef ROB_RECOVERY_PERF_EN
        ,
        .perf_flush_cnt_o (perf_flush_cnt_o),
        .perf_walk_cyc_o  (perf_walk_cyc_o)
`endif
    );

    always #5 clk = ~clk;

    // ROB contents, read combinationally through the walk ports.
    logic       mem_wen  [D];
    logic [5:0] mem_arch [D];
    logic [6:0] mem_t    [D];
    logic [6:0] mem_told [D];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            walk_rd_wen_i[k]          = mem_wen[walk_rd_idx_o[k*3 +: 3]];
            walk_rd_arch_i[k*6 +: 6]  = mem_arch[walk_rd_idx_o[k*3 +: 3]];
            walk_new_prf_i[k*7 +: 7]  = mem_t[walk_rd_idx_o[k*3 +: 3]];
            walk_old_prf_i[k*7 +: 7]  = mem_told[walk_rd_idx_o[k*3 +: 3]];
        end
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int pending[$];
    bit m_busy;
    int m_target;
    int m_head;
    int m_tail;
    int m_flush_cnt;
    int m_walk_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit older(input int a, input int b);
        return ((a - m_head + D) % D) < ((b - m_head + D) % D);
    endfunction

    task automatic randomize_rob();
        for (int i = 0; i < D; i++) begin
            mem_wen[i]  = ($urandom_range(0, 3) != 0);
            mem_arch[i] = 6'($urandom);
            mem_t[i]    = 7'($urandom);
            mem_told[i] = 7'($urandom);
        end
    endtask

    task automatic model_clear();
        pending.delete();
        m_busy      = 1'b0;
        m_target    = 0;
        m_flush_cnt = 0;
        m_walk_cyc  = 0;
    endtask

    // Compare every output with the model, then advance the model one cycle.
    task automatic eval_cycle();
        int   n;
        bit   done_c;
        bit   retgt;
        int   fidx;
        logic [1:0]  e_en, e_rv;
        logic [5:0]  e_idx;
        logic [11:0] e_arch;
        logic [13:0] e_rp, e_fp;
        e_en = '0; e_rv = '0; e_idx = '0; e_arch = '0; e_rp = '0; e_fp = '0;
        fidx = int'(flush_rob_idx_i);
        n = 0;
        if (m_busy) n = (pending.size() < 2) ? pending.size() : 2;
        for (int k = 0; k < n; k++) begin
            int e = pending[k];
            e_en[k]        = 1'b1;
            e_idx[k*3 +: 3] = 3'(e);
            if (mem_wen[e]) begin
                e_rv[k]          = 1'b1;
                e_arch[k*6 +: 6] = mem_arch[e];
                e_rp[k*7 +: 7]   = mem_told[e];
                e_fp[k*7 +: 7]   = mem_t[e];
            end
        end
        done_c = m_busy && (pending.size() == 0);
        retgt  = m_busy && flush_req_i && older(fidx, m_target);

        chk("rd_en",         32'(walk_rd_en_o),    32'(e_en));
        chk("rd_idx",        32'(walk_rd_idx_o),   32'(e_idx));
        chk("restore_valid", 32'(restore_valid_o), 32'(e_rv));
        chk("restore_arch",  32'(restore_arch_o),  32'(e_arch));
        chk("restore_prf",   32'(restore_prf_o),   32'(e_rp));
        chk("free_valid",    32'(free_valid_o),    32'(e_rv));
        chk("free_prf",      32'(free_prf_o),      32'(e_fp));
        chk("tail_set",      32'(tail_set_o),      32'(done_c && !retgt));
        chk("tail_set_idx",  32'(tail_set_idx_o),  (done_c && !retgt) ? 32'((m_target + 1) % D) : 32'd0);
        chk("disp_stall",    32'(disp_stall_o),    32'(m_busy));
        chk("busy",          32'(busy_o),          32'(m_busy));
`ifdef ROB_RECOVERY_PERF_EN
        chk("perf_flush_cnt", perf_flush_cnt_o, 32'(m_flush_cnt));
        chk("perf_walk_cyc",  perf_walk_cyc_o,  32'(m_walk_cyc));
`endif

        if (rst) return;
        if (!m_busy) begin
            if (flush_req_i) begin
                m_target = fidx;
                for (int e = (m_tail - 1 + D) % D; e != fidx; e = (e - 1 + D) % D)
                    pending.push_back(e);
                m_busy = 1'b1;
                m_flush_cnt++;
            end
        end else begin
            m_walk_cyc++;
            for (int k = 0; k < n; k++) void'(pending.pop_front());
            if (retgt) begin
                for (int e = m_target; e != fidx; e = (e - 1 + D) % D)
                    pending.push_back(e);
                m_target = fidx;
            end else if (done_c) begin
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic step(input bit fl, input int idx);
        @(negedge clk);
        flush_req_i     = fl;
        flush_rob_idx_i = 3'(idx);
        rob_head_i      = 3'(m_head);
        rob_tail_i      = 3'(m_tail);
        #1;
        eval_cycle();
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        flush_req_i = 1'b0;
        rst         = 1'b1;
        #1;
        model_clear();
        eval_cycle();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        int idx;
        rst = 1'b1;
        flush_req_i = 1'b0;
        flush_rob_idx_i = '0;
        rob_head_i = '0;
        rob_tail_i = '0;
        m_head = 0;
        m_tail = 0;
        randomize_rob();
        model_clear();
        #1;
        eval_cycle();
        @(negedge clk);
        rst = 1'b0;

        // Walk 5,4 | 3,2 then rewind to 2.
        m_head = 0; m_tail = 6;
        step(1, 1);
        repeat (4) step(0, 0);

        // Branch is youngest: straight to DONE, rewind to 6.
        step(1, 5);
        repeat (2) step(0, 0);

        // Wrapping walk 2,1 | 0 with a non-writing entry; rewind to 0.
        randomize_rob();
        mem_wen[1] = 1'b0;
        m_head = 6; m_tail = 3;
        step(1, 7);
        repeat (4) step(0, 0);

        // Older flush mid-walk extends the walk down to entry 3.
        m_head = 0; m_tail = 7;
        step(1, 4);
        step(1, 2);
        repeat (4) step(0, 0);

        // Younger flush mid-walk is ignored.
        step(1, 2);
        step(1, 5);
        repeat (4) step(0, 0);

        // Older flush arriving exactly in the DONE cycle.
        m_head = 1; m_tail = 5;
        step(1, 3);
        step(0, 0);
        step(1, 1);
        repeat (3) step(0, 0);

        // Reset mid-walk aborts immediately.
        m_head = 0; m_tail = 6;
        step(1, 1);
        step(0, 0);
        reset_pulse();
        repeat (2) step(0, 0);

        // Randomized recoveries with random mid-walk flushes.
        for (int r = 0; r < 150; r++) begin
            randomize_rob();
            cnt    = $urandom_range(1, D);
            m_head = $urandom_range(0, D - 1);
            m_tail = (m_head + cnt) % D;
            idx    = (m_head + $urandom_range(0, cnt - 1)) % D;
            step(1, idx);
            for (int c = 0; c < 24 && m_busy; c++) begin
                idx = (m_head + $urandom_range(0, cnt - 1)) % D;
                step($urandom_range(0, 3) == 0, idx);
            end
            step(0, 0);
            if ($urandom_range(0, 19) == 0) reset_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
